// File: rtl/coax_tx_arbiter.sv
// coax_tx_arbiter: round-robin, whole-frame arbiter sharing one buffered coax
// transmitter between two requesters. Words stream into the transmitter buffer.
// The arbiter then strobes start, waits for the transmission to end, and
// enforces an idle gap before the next grant.
// Optional build macro COAX_TX_ARBITER_WATCHDOG_EN adds a wait-state watchdog.
module coax_tx_arbiter #(
    parameter int GAP_CLOCKS     = 16,
    parameter int TIMEOUT_CLOCKS = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [9:0] req0_data,
    input  logic       req0_last,
    input  logic       req0_protocol,
    input  logic       req0_parity,
    output logic       req0_ready,
    output logic       req0_done,
    input  logic       req1_valid,
    input  logic [9:0] req1_data,
    input  logic       req1_last,
    input  logic       req1_protocol,
    input  logic       req1_parity,
    output logic       req1_ready,
    output logic       req1_done,
    output logic [9:0] tx_data,
    output logic       tx_load_strobe,
    output logic       tx_start_strobe,
    output logic       tx_protocol,
    output logic       tx_parity,
    input  logic       tx_full,
    input  logic       tx_empty,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       busy,
    output logic       error
);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t      state, state_nx;
    logic [1:0]  grant_nx;
    logic        ptr;        // requester preferred when both are valid
    logic        pick;       // winner index in IDLE
    logic        eligible;
    logic        accept;
    logic        sel_last;
    logic        done_nx;
    logic        error_nx;
    logic        wd_expire;
    logic [15:0] gap_cnt;

    // Winner selection: a lone valid requester wins, otherwise the pointer decides.
    assign pick     = (req0_valid & req1_valid) ? ptr : req1_valid;
    assign eligible = tx_empty & tx_ready & (req0_valid | req1_valid);

    // Only the owner sees ready, and only while loading with buffer room.
    assign req0_ready     = (state == LOAD) & grant[0] & ~tx_full;
    assign req1_ready     = (state == LOAD) & grant[1] & ~tx_full;
    assign accept         = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign tx_load_strobe = accept;
    assign sel_last       = grant[1] ? req1_last : req0_last;
    assign tx_data        = (state != LOAD) ? 10'd0 : (grant[1] ? req1_data : req0_data);
    assign busy           = (state != IDLE);

`ifdef COAX_TX_ARBITER_WATCHDOG_EN
    logic [15:0] wd_cnt;

    // Watchdog counts every clock spent waiting on the transmitter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wd_cnt <= 16'd0;
        else if (state == START)
            wd_cnt <= 16'd0;
        else if (state == WAIT_BUSY || state == WAIT_DONE)
            wd_cnt <= wd_cnt + 16'd1;
    end

    assign wd_expire = (wd_cnt == 16'(TIMEOUT_CLOCKS - 1));
`else
    assign wd_expire = 1'b0;
`endif

    // Next-state logic; frame end and watchdog expiry both release the grant.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        done_nx  = 1'b0;
        error_nx = 1'b0;
        case (state)
            IDLE: if (eligible) begin
                state_nx = LOAD;
                grant_nx = pick ? 2'b10 : 2'b01;
            end
            LOAD: if (accept && sel_last) state_nx = START;
            START: state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!tx_ready)
                    state_nx = WAIT_DONE;
                else if (wd_expire)
                    error_nx = 1'b1;
            end
            WAIT_DONE: begin
                if (tx_ready)
                    done_nx = 1'b1;
                else if (wd_expire)
                    error_nx = 1'b1;
            end
            GAP: if (gap_cnt == 16'(GAP_CLOCKS - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (done_nx || error_nx) begin
            state_nx = (GAP_CLOCKS == 0) ? IDLE : GAP;
            grant_nx = 2'b00;
        end
    end

    // State, ownership, frame settings and one-clock pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            grant           <= 2'b00;
            ptr             <= 1'b0;
            tx_protocol     <= 1'b0;
            tx_parity       <= 1'b0;
            tx_start_strobe <= 1'b0;
            req0_done       <= 1'b0;
            req1_done       <= 1'b0;
            error           <= 1'b0;
        end else begin
            state           <= state_nx;
            grant           <= grant_nx;
            tx_start_strobe <= (state == LOAD) && (state_nx == START);
            req0_done       <= done_nx & grant[0];
            req1_done       <= done_nx & grant[1];
            error           <= error_nx;
            if (state == IDLE && eligible) begin
                ptr         <= ~pick;
                tx_protocol <= pick ? req1_protocol : req0_protocol;
                tx_parity   <= pick ? req1_parity : req0_parity;
            end
        end
    end

    // Gap counter runs only while in GAP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            gap_cnt <= 16'd0;
        else if (state == GAP)
            gap_cnt <= gap_cnt + 16'd1;
        else
            gap_cnt <= 16'd0;
    end

endmodule
